// File: rtl/operand_feeder_pkg.sv
// Shared types and sizing for the systolic-array operand feeder.
// Lane vectors pack word i at bits [i*NUM_BITS +: NUM_BITS].
package operand_feeder_pkg;

  localparam int N        = 4;
  localparam int NUM_BITS = 8;

  typedef enum logic [1:0] {
    FEED_LOAD,
    FEED_FULL,
    FEED_STREAM
  } feeder_state_t;

  typedef logic [N*NUM_BITS-1:0] lane_t;

  // Width helper that never collapses to zero bits for tiny arrays.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/operand_feeder_bank.sv
// N x N operand storage: one write column per load beat, skewed per-lane read.
// Lane l holds word k at mem[l][k]; the read returns mem[l][t-l] inside the window, else 0.
module operand_feeder_bank
  import operand_feeder_pkg::*;
#(
  parameter int N        = operand_feeder_pkg::N,
  parameter int NUM_BITS = operand_feeder_pkg::NUM_BITS,
  localparam int KW      = safe_clog2(N),
  localparam int TW      = safe_clog2(2*N-1)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [KW-1:0]         wk_i,
  input  logic [N*NUM_BITS-1:0] wdata_i,
  input  logic [TW-1:0]         t_i,
  output logic [N*NUM_BITS-1:0] rdata_o
);

  logic [NUM_BITS-1:0] mem_q [N][N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned l = 0; l < N; l++) begin
        mem_q[l][wk_i] <= wdata_i[l*NUM_BITS +: NUM_BITS];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned l = 0; l < N; l++) begin
      if ((32'(t_i) >= l) && ((32'(t_i) - l) < 32'(N))) begin
        rdata_o[l*NUM_BITS +: NUM_BITS] = mem_q[l][KW'(32'(t_i) - l)];
      end
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Loads one N x N operand pair over valid/ready, then streams A west and B north
// with the diagonal skew the PE array needs; idle lanes carry zero.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int N        = operand_feeder_pkg::N,
  parameter int NUM_BITS = operand_feeder_pkg::NUM_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N*NUM_BITS-1:0] a_col_i,
  input  logic [N*NUM_BITS-1:0] b_row_i,
  input  logic                  start_i,
  output logic                  full_o,
  output logic [N*NUM_BITS-1:0] left_o,
  output logic [N*NUM_BITS-1:0] top_o,
  output logic                  feed_valid_o,
  output logic                  done_o
);

  localparam int CW = safe_clog2(N+1);
  localparam int TW = safe_clog2(2*N-1);
  localparam int KW = safe_clog2(N);

  feeder_state_t         state_q;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         t_q;
  logic                  in_ready_q, full_q, feed_valid_q, done_q;
  logic [N*NUM_BITS-1:0] left_q, top_q;

  logic                  we;
  logic [TW-1:0]         rd_t;
  logic [N*NUM_BITS-1:0] a_rd, b_rd;

  // The lanes are registered, so the bank is read one step ahead of t_q.
  always_comb begin
    we   = in_valid_i & in_ready_q;
    rd_t = (state_q == FEED_STREAM) ? t_q + 1'b1 : '0;
  end

  operand_feeder_bank #(.N(N), .NUM_BITS(NUM_BITS)) u_bank_a (
    .clk_i   (clk_i),
    .we_i    (we),
    .wk_i    (KW'(cnt_q)),
    .wdata_i (a_col_i),
    .t_i     (rd_t),
    .rdata_o (a_rd)
  );

  operand_feeder_bank #(.N(N), .NUM_BITS(NUM_BITS)) u_bank_b (
    .clk_i   (clk_i),
    .we_i    (we),
    .wk_i    (KW'(cnt_q)),
    .wdata_i (b_row_i),
    .t_i     (rd_t),
    .rdata_o (b_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FEED_LOAD;
      cnt_q        <= '0;
      t_q          <= '0;
      in_ready_q   <= 1'b1;
      full_q       <= 1'b0;
      feed_valid_q <= 1'b0;
      done_q       <= 1'b0;
      left_q       <= '0;
      top_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        FEED_LOAD: begin
          if (we) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(N-1)) begin
              state_q    <= FEED_FULL;
              in_ready_q <= 1'b0;
              full_q     <= 1'b1;
            end
          end
        end
        FEED_FULL: begin
          if (start_i) begin
            state_q      <= FEED_STREAM;
            t_q          <= '0;
            full_q       <= 1'b0;
            feed_valid_q <= 1'b1;
            left_q       <= a_rd;
            top_q        <= b_rd;
          end
        end
        FEED_STREAM: begin
          if (t_q == TW'(2*N-2)) begin
            state_q      <= FEED_LOAD;
            t_q          <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            feed_valid_q <= 1'b0;
            done_q       <= 1'b1;
            left_q       <= '0;
            top_q        <= '0;
          end else begin
            t_q    <= t_q + 1'b1;
            left_q <= a_rd;
            top_q  <= b_rd;
          end
        end
        default: state_q <= FEED_LOAD;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign full_o       = full_q;
  assign feed_valid_o = feed_valid_q;
  assign done_o       = done_q;
  assign left_o       = left_q;
  assign top_o        = top_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: matrix-level reference model compared every
// cycle, plus hand-computed literals for the common N=4 operand set.
module tb_operand_feeder;
  import operand_feeder_pkg::*;

  localparam int NN = N;
  localparam int W  = NUM_BITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NN*W-1:0]   a_col, b_row;
  logic              start;
  logic              full;
  logic [NN*W-1:0]   left, top;
  logic              feed_valid, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_feeder #(.N(NN), .NUM_BITS(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_col_i      (a_col),
    .b_row_i      (b_row),
    .start_i      (start),
    .full_o       (full),
    .left_o       (left),
    .top_o        (top),
    .feed_valid_o (feed_valid),
    .done_o       (done)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: matrices as captured from handshaked beats, plus job phase.
  int mA [NN][NN];
  int mB [NN][NN];
  int m_phase = 0;   // 0 loading, 1 full, 2 streaming
  int m_beats = 0;
  int m_step  = -1;  // stream step visible on the lanes, -1 when none
  bit m_done  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_beats = 0; m_step = -1; m_done = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (in_valid) begin
          for (int i = 0; i < NN; i++) begin
            mA[i][m_beats] = int'(a_col[i*W +: W]);
            mB[m_beats][i] = int'(b_row[i*W +: W]);
          end
          m_beats++;
          if (m_beats == NN) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (start) begin m_phase = 2; m_step = 0; end
      end else begin
        if (m_step == 2*NN-2) begin
          m_phase = 0; m_step = -1; m_beats = 0; m_done = 1;
        end else begin
          m_step++;
        end
      end
    end
  end

  function automatic int exp_left(input int i);
    int k = m_step - i;
    if (m_step >= 0 && k >= 0 && k < NN) return mA[i][k];
    return 0;
  endfunction

  function automatic int exp_top(input int j);
    int k = m_step - j;
    if (m_step >= 0 && k >= 0 && k < NN) return mB[k][j];
    return 0;
  endfunction

  always @(negedge clk) begin
    check("in_ready", 64'(in_ready), 64'(m_phase == 0));
    check("full", 64'(full), 64'(m_phase == 1));
    check("feed_valid", 64'(feed_valid), 64'(m_step >= 0));
    check("done", 64'(done), 64'(m_done));
    for (int i = 0; i < NN; i++) begin
      check($sformatf("left[%0d]", i), 64'(left[i*W +: W]), 64'(exp_left(i)));
      check($sformatf("top[%0d]", i), 64'(top[i*W +: W]), 64'(exp_top(i)));
    end
  end

  // Random load with random gaps and ignored start pulses; ends in the cycle full_o is seen.
  task automatic load_random();
    int n = 0;
    forever begin
      in_valid = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 5) == 0);
      a_col    = (NN*W)'({$urandom, $urandom});
      b_row    = (NN*W)'({$urandom, $urandom});
      @(negedge clk);
      if (full) break;
      n++;
      if (n > 200) begin check("load_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Start after a random delay; ends in the done_o cycle.
  task automatic stream_random();
    int n = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (done) break;
      in_valid = ($urandom_range(0, 3) == 0);
      start    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n++;
      if (n > 50) begin check("done_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; a_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Start while loading is ignored.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("idle_ready", 64'(in_ready), 1);
    check("idle_full", 64'(full), 0);

    // Directed load of the common operands.
    for (int k = 0; k < NN; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < NN; i++) begin
        a_col[i*W +: W] = W'(10*i + k);
        b_row[i*W +: W] = W'(100 + 10*k + i);
      end
      @(negedge clk);
    end
    check("lit_full_after_4", 64'(full), 1);
    check("lit_ready_after_4", 64'(in_ready), 0);
    a_col = '1; b_row = '1;   // 5th beat, must be ignored
    @(negedge clk);
    in_valid = 1'b0;

    start = 1'b1;             // cycle c
    @(negedge clk);
    start = 1'b0;             // c+1
    check("lit_c1_left0", 64'(left[0 +: W]), 0);
    check("lit_c1_left1", 64'(left[W +: W]), 0);
    check("lit_c1_top0", 64'(top[0 +: W]), 100);
    check("lit_c1_top1", 64'(top[W +: W]), 0);
    check("lit_c1_full", 64'(full), 0);
    repeat (3) @(negedge clk); // c+4
    check("lit_c4_left", 64'(left), 64'({8'd30, 8'd21, 8'd12, 8'd3}));
    check("lit_c4_top", 64'(top), 64'({8'd103, 8'd112, 8'd121, 8'd130}));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk); // c+7
    check("lit_c7_left", 64'(left), 64'({8'd33, 24'd0}));
    check("lit_c7_top", 64'(top), 64'({8'd133, 24'd0}));
    check("lit_c7_valid", 64'(feed_valid), 1);
    @(negedge clk);            // c+8
    check("lit_c8_done", 64'(done), 1);
    check("lit_c8_ready", 64'(in_ready), 1);
    check("lit_c8_valid", 64'(feed_valid), 0);
    check("lit_c8_lanes", 64'({left, top}), 0);
    @(negedge clk);            // c+9
    check("lit_c9_done", 64'(done), 0);

    // Reset mid-stream at t=2.
    load_random();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("lit_rst_lanes", 64'({left, top}), 0);
    check("lit_rst_valid", 64'(feed_valid), 0);
    check("lit_rst_ready", 64'(in_ready), 1);
    check("lit_rst_done", 64'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Back-to-back random jobs: each load starts in the previous done_o cycle.
    for (int j = 0; j < 8; j++) begin
      load_random();
      stream_random();
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
